// File: rtl/data_port_arbiter_pkg.sv
// Shared types for the data-port arbiter.
//   arb_state_t : port ownership (IDLE = no owner, OWN0/OWN1 = locked to a master)
//   mid_t       : master id, 0 = CPU data port, 1 = debug/loader master
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic mid_t;

    localparam mid_t MID_CPU = 1'b0;
    localparam mid_t MID_DBG = 1'b1;

    function automatic arb_state_t own_state(input mid_t id);
        return (id == MID_DBG) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way pick for the data-port arbiter.
//   req[1:0]     : per-master request
//   last_winner  : master that won the previous handshake
//   own_valid    : port is locked to own_id
//   own_id       : current owner when locked
//   gnt[1:0]     : one-hot (or zero) grant
module rr_pick2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  mid_t       last_winner,
    input  logic       own_valid,
    input  mid_t       own_id,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (own_valid) begin
            // Locked: only the owner may go, the other master waits.
            gnt[own_id] = req[own_id];
        end else if (&req) begin
            // Tie: the master that did not win last time goes.
            gnt[~last_winner] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares one data RAM / confreg port between the CPU data port (m0) and the
// debug/loader master (m1). Round-robin per transfer, with a bounded lock
// that lets one master keep the port for back-to-back transfers.
//   clk, reset            : clock, async active-high reset
//   mX_req/we/lock        : master X request, write enable, keep-ownership
//   mX_addr/wdata         : master X address / write data
//   mX_gnt                : handshake this cycle (with mX_req)
//   mX_rvalid/rdata       : read response, one cycle after a read handshake
//   s_en/we/addr/wdata    : slave access, muxed from the granted master
//   s_rdata               : slave read data (combinational RAM read)
module data_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          s_en,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata
);

    localparam int             CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_LOCK - 1);

    arb_state_t    state, state_nx;
    logic [CW-1:0] lock_cnt, lock_cnt_nx;
    mid_t          last_winner, last_winner_nx;

    logic [1:0]    req, pick, gnt;
    logic          hs, win_we, win_lock;
    mid_t          win_id;

    logic          rd_pend;
    mid_t          rd_id;
    logic [DW-1:0] m0_rdata_q, m1_rdata_q;

    assign req = {m1_req, m0_req};

    rr_pick2 u_pick (
        .req         (req),
        .last_winner (last_winner),
        .own_valid   (state != IDLE),
        .own_id      ((state == OWN1) ? MID_DBG : MID_CPU),
        .gnt         (pick)
    );

    // No grant may be seen while reset is held, even with requests pending.
    assign gnt      = reset ? 2'b00 : pick;
    assign hs       = |gnt;
    assign win_id   = gnt[1] ? MID_DBG : MID_CPU;
    assign win_we   = (win_id == MID_DBG) ? m1_we   : m0_we;
    assign win_lock = (win_id == MID_DBG) ? m1_lock : m0_lock;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lock_cnt    <= '0;
            last_winner <= MID_DBG;
        end else begin
            state       <= state_nx;
            lock_cnt    <= lock_cnt_nx;
            last_winner <= last_winner_nx;
        end
    end

    // Next state. In OWNx only mx can handshake, so a handshake always
    // belongs to the owner (or starts a new ownership from IDLE).
    always_comb begin
        state_nx       = state;
        lock_cnt_nx    = lock_cnt;
        last_winner_nx = last_winner;
        if (hs) begin
            last_winner_nx = win_id;
            if (win_lock && (lock_cnt < CNT_LAST)) begin
                state_nx    = own_state(win_id);
                lock_cnt_nx = lock_cnt + 1'b1;
            end else begin
                // Unlocked transfer or lock budget exhausted: release.
                state_nx    = IDLE;
                lock_cnt_nx = '0;
            end
        end else if (state != IDLE) begin
            // Owner stopped requesting: drop the lock quietly.
            state_nx    = IDLE;
            lock_cnt_nx = '0;
        end
    end

    // Outputs
    always_comb begin
        m0_gnt  = gnt[0];
        m1_gnt  = gnt[1];
        s_en    = hs;
        s_we    = hs & win_we;
        s_addr  = gnt[1] ? m1_addr  : m0_addr;
        s_wdata = gnt[1] ? m1_wdata : m0_wdata;
    end

    // Read return: capture at the read handshake, present next cycle.
    // Each master keeps its own copy so rdata holds until its next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            rd_id      <= MID_CPU;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rd_pend <= hs & ~win_we;
            if (hs && !win_we) begin
                rd_id <= win_id;
                if (win_id == MID_DBG) m1_rdata_q <= s_rdata;
                else                   m0_rdata_q <= s_rdata;
            end
        end
    end

    assign m0_rvalid = rd_pend & (rd_id == MID_CPU);
    assign m1_rvalid = rd_pend & (rd_id == MID_DBG);
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
module tb_data_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_en, s_we;

    data_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    // Slave RAM (written by the DUT) and the bench's own expected memory.
    logic [31:0] ram     [0:1023];
    logic [31:0] exp_mem [0:1023];
    assign s_rdata = ram[s_addr[11:2]];
    always @(posedge clk) if (s_en && s_we) ram[s_addr[11:2]] <= s_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read scoreboard: pushed when a read grant is expected, popped when due.
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;
    logic mon_v0, mon_v1;

    always @(negedge clk) begin
        mon_v0 = 1'b0;
        mon_v1 = 1'b0;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("rd_latency", 64'(mon_e.due), 64'(cyc));
            mon_v0 = !mon_e.id;
            mon_v1 = mon_e.id;
        end
        check("rvalid", {m1_rvalid, m0_rvalid}, {mon_v1, mon_v0});
        if (mon_v0) check("m0_rdata", m0_rdata, mon_e.data);
        if (mon_v1) check("m1_rdata", m1_rdata, mon_e.data);
    end

    task automatic drv(input int m, input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // One cycle: check grants and the slave mux mid-cycle, update the model.
    task automatic step(input string tag, input logic eg0, input logic eg1);
        logic [31:0] a, d;
        logic        w;
        @(negedge clk);
        check({tag, "/gnt"}, {m1_gnt, m0_gnt}, {eg1, eg0});
        check({tag, "/s_en"}, s_en, eg0 | eg1);
        if (eg0 | eg1) begin
            a = eg1 ? m1_addr  : m0_addr;
            d = eg1 ? m1_wdata : m0_wdata;
            w = eg1 ? m1_we    : m0_we;
            check({tag, "/s_addr"}, s_addr, a);
            check({tag, "/s_we"}, s_we, w);
            if (w) begin
                check({tag, "/s_wdata"}, s_wdata, d);
                exp_mem[a[11:2]] = d;
            end else begin
                sb.push_back('{id: eg1, data: exp_mem[a[11:2]], due: cyc + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 32'hA500_0000 | 32'(i);
            exp_mem[i] = 32'hA500_0000 | 32'(i);
        end
        reset = 1'b1;
        drv(0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0);

        // 1: reset held with both requesting
        repeat (3) begin
            @(negedge clk);
            check("rst/gnt", {m1_gnt, m0_gnt}, 2'b00);
            check("rst/s_en", s_en, 1'b0);
            check("rst/rdata", {m1_rdata, m0_rdata}, 64'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // 2: tie round robin on reads, m0 first after reset
        step("rr0", 1, 0);
        step("rr1", 0, 1);
        step("rr2", 1, 0);
        step("rr3", 0, 1);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rr_idle", 0, 0);

        // 3: locked write burst by m0, m1 held off until after the unlocked one
        drv(1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h55);
        drv(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h11); step("lk0", 1, 0);
        drv(0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h12); step("lk1", 1, 0);
        drv(0, 1'b1, 1'b1, 1'b1, 32'h108, 32'h13); step("lk2", 1, 0);
        drv(0, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h14); step("lk3", 1, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);    step("lk_m1", 0, 1);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // 4: forced release after MAX_LOCK grants
        drv(1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h66);
        for (int k = 0; k < ML; k++) begin
            drv(0, 1'b1, 1'b1, 1'b1, 32'h600 + 32'(4 * k), 32'h70 + 32'(k));
            step("frc_m0", 1, 0);
        end
        step("frc_m1", 0, 1);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // abandoned lock: owner drops req, other master waits one cycle
        drv(0, 1'b1, 1'b1, 1'b1, 32'h610, 32'h80); step("abn_m0", 1, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b1, 1'b1, 1'b0, 32'h700, 32'h99); step("abn_wait", 0, 0);
        step("abn_m1", 0, 1);

        // 5: m1 write then m0 read of the same word, no bubble
        drv(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'hDEADBEEF); step("rd_wr", 0, 1);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);        step("rd_rd", 1, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rd_ret", 0, 0);
        step("rd_hold", 0, 0);
        @(negedge clk);
        check("m0_rdata_hold", m0_rdata, 32'hDEADBEEF);
        check("m1_rdata_hold", m1_rdata, 32'hA500_0000 | 32'(32'h304 >> 2));
        @(posedge clk);
        #1;

        // 6: reset with a lock held and a read response pending
        drv(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0); step("r6_rd", 1, 0);
        reset = 1'b1;
        sb.delete();
        drv(1, 1'b1, 1'b0, 1'b0, 32'h108, 32'h0);
        drv(0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        check("r6/gnt", {m1_gnt, m0_gnt}, 2'b00);
        check("r6/rdata", m0_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        step("r6_tie", 1, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("r6_ret", 0, 0);
        step("r6_idle", 0, 0);

        // Writes landed where intended
        foreach (exp_mem[i]) if (exp_mem[i] !== (32'hA500_0000 | 32'(i)))
            check("ram_data", ram[i], exp_mem[i]);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
